serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial adder controller that sequences a single `fullAdd` instance (ports `x`, `y`, `z`, `fsum`, `c`) across WIDTH-bit operands, one bit per clock, LSB first. It latches operands on a start request, steps the full adder through every bit position while carrying between cycles in a register, and presents the registered sum and carry-out with a one-cycle done pulse. It is the team's area-minimal adder for multi-bit operations, trading latency for one full-adder cell.

## Interface
- `WIDTH`, 8, operand and sum width in bits; legal range is 1 to 64.
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request to begin an addition; sampled only in IDLE or DONE.
- `a`  input  WIDTH  operand A; sampled on the accepting edge only.
- `b`  input  WIDTH  operand B; sampled on the accepting edge only.
- `cin`  input  1  carry-in; sampled on the accepting edge only.
- `busy`  output  1  high while bits are being processed (RUN state).
- `done`  output  1  one-cycle pulse when `sum` and `cout` become valid.
- `sum`  output  WIDTH  registered result; held until the next completion or reset.
- `cout`  output  1  registered carry-out of the MSB; held like `sum`.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE transitions:
  - `start`=1: load `a` and `b` into shift registers, load `cin` into the carry register, clear the bit counter, go to RUN.
  - `start`=0: stay in IDLE.
- RUN, each cycle:
  - Drive `fullAdd` with `x`=A shift register bit 0, `y`=B shift register bit 0, `z`=carry register.
  - On the edge, shift A and B right by one bit.
  - Shift `fsum` into the MSB of the result shift register. After WIDTH shifts, bit 0 holds the LSB result.
  - Set carry register to `c` and increment the counter.
- RUN to DONE: on the edge that processes bit WIDTH-1, copy the result shift register to `sum`, copy final `c` to `cout`, and go to DONE.
- `start` is ignored in RUN. An in-flight operation is never aborted except by `rst`.
- DONE (one cycle):
  - `start`=1: accepted exactly as in IDLE, giving back-to-back operation with no idle cycle.
  - `start`=0: go to IDLE.
- Arithmetic: unsigned {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1). The bit counter is $clog2(WIDTH+1) bits wide, so it never wraps before reaching WIDTH.
- `rst`=1 on any edge, including mid-RUN:
  - State goes to IDLE.
  - Shift registers, carry register and counter clear to 0.
  - `sum`, `cout`, `busy`, `done` go to 0.
  - The partial result is discarded. `rst` takes priority over `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0.
- Cycle numbering: start is accepted at edge E0.
- `busy` is 1 from after E0 until E(WIDTH). Bits 0..WIDTH-1 are processed at edges E1..E(WIDTH).
- `done`=1 and `sum`/`cout` update after E(WIDTH). `done` returns to 0 after E(WIDTH+1) unless it is re-asserted by a new completion.
- Latency from start edge to results valid: WIDTH cycles.
- Throughput: one addition per WIDTH+1 cycles when `start` is held high continuously.
- `sum`/`cout` change only at completion or reset, never during RUN.
- `done` and `busy` are never high in the same cycle.

## Configuration
- Macro: `SERIAL_ADD_OVF_EN`.
- Defined:
  - Adds output port `ovf` (1 bit, reset value 0) for signed two's-complement overflow.
  - `ovf` = carry into the MSB XOR carry out of the MSB.
  - It is captured at the same edge as `sum` and held on the same terms.
  - This requires registering the carry before the final bit.
- Not defined:
  - No `ovf` port and no extra register.
  - The remaining behaviour is identical.

## Test plan
- WIDTH=8, `a`=8'h35, `b`=8'h4A, `cin`=0, `start` for one cycle -> `busy` high for 8 cycles, `done` pulse at cycle 8 after accept, `sum`=8'h7F, `cout`=0.
- `a`=8'hFF, `b`=8'h01, `cin`=0 -> `sum`=8'h00, `cout`=1. Then `a`=0, `b`=0, `cin`=1 -> `sum`=8'h01, `cout`=0.
- `start` pulsed again at cycle 3 of RUN with different operands -> ignored; the result matches the first operands and only one `done` pulse occurs.
- `rst` asserted at cycle 4 of RUN -> next cycle `busy`=0, `done`=0, `sum`=0, `cout`=0. A fresh start then completes correctly.
- `start` held high across two operations (8'h10+8'h20, then 8'hF0+8'h20) -> `done` at cycles 8 and 17, giving `sum`=8'h30/`cout`=0 and then `sum`=8'h10/`cout`=1.
- With `SERIAL_ADD_OVF_EN`: 8'h7F+8'h01 -> `ovf`=1; 8'hFF+8'h01 -> `ovf`=0; 8'h80+8'h80 -> `ovf`=1, `cout`=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller built around one fullAdd cell.
// Operands are latched on an accepted start, then added one bit per clock,
// LSB first. The carry is kept in a register between bits. The registered
// sum/cout are presented with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADD_OVF_EN adds a registered signed-overflow
// output `ovf`.

// Single-bit full adder cell that the controller steps across the operand.
module fullAdd (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic fsum,
  output logic c
);

  // Sum and carry of three one-bit inputs.
  always_comb begin
    fsum = x ^ y ^ z;
    c    = (x & y) | (x & z) | (y & z);
  end

endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_c;

  fullAdd u_fa (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .z    (carry),
    .fsum (fa_sum),
    .c    (fa_c)
  );

  // Result shift register after inserting the current bit at the MSB end.
  // A one-bit adder has nothing to shift, so it is special-cased.
  generate
    if (WIDTH == 1) begin : g_res_w1
      always_comb res_next = fa_sum;
    end else begin : g_res_wn
      always_comb res_next = {fa_sum, res_sr[WIDTH-1:1]};
    end
  endgenerate

  // Status outputs decode directly from the registered state.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Sequencer: accept operands, step one bit per clock, capture the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            sum   <= res_next;
            cout  <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB on this edge
            ovf   <= carry ^ fa_c;
`endif
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
